// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply unit.
// States, datapath widths and the PC register index.
package mul_pkg;

    localparam int DATA_W = 32;
    localparam int STEP_W = 8;

    localparam logic [3:0] PC_ADDR = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One multiply-accumulate step.
// Computes acc + m * s[STEP_W-1:0], truncated to DATA_W bits.
module mul_step
    import mul_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int SW = STEP_W
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] m,
    input  logic [SW-1:0] s_lo,
    output logic [DW-1:0] acc_nxt
);

    logic [DW-1:0] prod;

    // Partial product and running sum, both modulo 2^DW
    always_comb begin
        prod    = m * DW'(s_lo);
        acc_nxt = acc + prod;
    end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative MUL/MLA stage: Rs consumed one byte per cycle.
// Writes Rd on port 3 and raises optional N/Z flag updates.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int SW = STEP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          accumulate,
    input  logic          set_flags,
    input  logic [DW-1:0] rm_data,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rn_data,
    input  logic [3:0]    rd_addr,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [3:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          flag_wr,
    output logic          flag_n,
    output logic          flag_z
);

    mul_state_t state;
    mul_state_t state_nxt;

    logic [DW-1:0] acc;
    logic [DW-1:0] m;
    logic [DW-1:0] s;
    logic [3:0]    rd;
    logic          sflag;

    logic [DW-1:0] acc_nxt;
    logic [DW-1:0] s_nxt;
    logic          last;

    mul_step #(
        .DW (DW),
        .SW (SW)
    ) u_step (
        .acc     (acc),
        .m       (m),
        .s_lo    (s[SW-1:0]),
        .acc_nxt (acc_nxt)
    );

    assign s_nxt = s >> SW;
    assign last  = (s_nxt == '0);
    assign busy  = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: CALC repeats until the remaining multiplier is zero
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (last)  state_nxt = ST_WB;
            ST_WB:              state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, iteration and registered write-back pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m       <= '0;
            s       <= '0;
            rd      <= '0;
            sflag   <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            flag_wr <= 1'b0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            done    <= 1'b0;
            wr_en   <= 1'b0;
            flag_wr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        m     <= rm_data;
                        s     <= rs_data;
                        rd    <= rd_addr;
                        sflag <= set_flags;
                        acc   <= accumulate ? rn_data : '0;
                    end
                end
                ST_CALC: begin
                    acc <= acc_nxt;
                    m   <= m << SW;
                    s   <= s_nxt;
                    if (last) begin
                        done    <= 1'b1;
                        wr_en   <= (rd != PC_ADDR);
                        wr_addr <= rd;
                        wr_data <= acc_nxt;
                        flag_wr <= sflag;
                        flag_n  <= acc_nxt[DW-1];
                        flag_z  <= (acc_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Multi-cycle multiply/multiply-accumulate execution stage placed directly downstream of the `reg_sync` register file. It consumes the Rm/Rs/Rn operands read on the register-file output buses and computes Rd = Rm·Rs (+Rn). Rs is processed 8 bits per cycle with early termination. It drives the result back into register-file write port 3 and produces N/Z flag updates for the CPSR path.

## Interface
- `DATA_W`, 32, operand/result width; fixed at 32 for this core.
- `STEP_W`, 8, Rs bits consumed per CALC cycle; must divide `DATA_W`.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `accumulate`  in  1  1 = MLA (add `rn_data`), 0 = MUL
- `set_flags`  in  1  S bit; request N/Z update
- `rm_data`  in  32  multiplicand (register-file `out_data_1`)
- `rs_data`  in  32  multiplier (register-file `out_data_2`)
- `rn_data`  in  32  accumulate operand (register-file `out_data_3`)
- `rd_addr`  in  4  destination register
- `busy`  out  1  operation in progress (CALC or WB)
- `done`  out  1  one-cycle completion pulse
- `wr_en`  out  1  to `write_enable_3`
- `wr_addr`  out  4  to `write_address_3`
- `wr_data`  out  32  to `write_data_3`
- `flag_wr`  out  1  CPSR N/Z write strobe
- `flag_n`, `flag_z`  out  1 each  new N and Z values

## Operation
- States: IDLE, CALC, WB.
- IDLE: `start`=1 captures `rm_data`→M, `rs_data`→S, `rd_addr`, `set_flags`, and ACC = `accumulate` ? `rn_data` : 0. Next state is CALC.
- CALC, each cycle:
  - ACC += M · S[7:0], modulo 2^32.
  - M <<= 8; S >>= 8 (logical).
  - If the shifted S == 0, next state is WB; otherwise stay in CALC.
- CALC cycle count n = max(1, ceil(msb_index(Rs)+1 / 8)). Rs=0 gives n=1; Rs≥2^24 gives n=4.
- Only the low 32 bits are produced, so the result is sign-agnostic. Long multiplies are out of scope.
- WB:
  - `wr_en`=1, `wr_addr`=Rd, `wr_data`=ACC, `done`=1.
  - `flag_wr`=latched S bit, `flag_n`=ACC[31], `flag_z`=(ACC==0).
  - Next state is IDLE.
- Rd == 15 (PC): `wr_en` is held 0 in WB. `done` and the flag outputs still behave normally.
- `start` in CALC or WB is ignored, not queued.
- Inputs are not required to stay stable after the capture edge.

## Timing
- Reset (async assert, state forced to IDLE): `busy`, `done`, `wr_en`, `flag_wr`, `flag_n`, `flag_z` = 0; `wr_addr` = 0; `wr_data` = 0; internal ACC/M/S = 0.
- Reset deasserts synchronously to `clk` (external synchronizer); first `start` is sampled at the first edge after deassertion.
- `start` sampled at edge E0 → CALC during cycles 1..n → WB during cycle n+1 → IDLE at edge n+2.
- Latency from start to write-back is n+1 cycles; initiation interval is n+2.
- `busy` = 1 from the cycle after E0 through the WB cycle. `start` in the same cycle `busy` falls (the IDLE cycle) is accepted.
- `wr_en`, `done`, `flag_wr` are registered and high for exactly one cycle.
- `wr_data`/`wr_addr` hold their last values outside WB; they are qualified only by `wr_en`.
- Reset mid-CALC or mid-WB aborts the operation: no write-back or flag pulse after reset, and no partial result is retained.
- Operand hazards (Rd equal to a source register) are resolved upstream. The unit reads only its captured copies.

## Structure
- Package `mul_pkg`:
  - state enum (IDLE/CALC/WB);
  - `DATA_W`, `STEP_W`, `PC_ADDR` = 4'd15.
- Sub-module `mul_step`: combinational ACC + M·S[STEP_W-1:0]. The FSM, operand registers and write-back registers live in `mul_iter_unit`.

## Test plan
- Rm=2, Rs=1, MUL, Rd=2 → n=1; at cycle 2 `wr_en`=1, `wr_addr`=2, `wr_data`=0x00000002, `done`=1.
- Rm=3, Rs=0x01000000, MUL → n=4; `busy` high for 5 cycles; `wr_data`=0x03000000 at cycle 5.
- MLA with Rm=0xFFFFFFFF, Rs=2, Rn=5 → n=1; `wr_data`=0x00000003 (wrap-around). Rs=0, Rn=7 → n=1, `wr_data`=7.
- `set_flags`=1, Rm=0x80000000, Rs=1 → `flag_wr`=1, `flag_n`=1, `flag_z`=0. Rs=0 → `flag_z`=1, `flag_n`=0. With `set_flags`=0, `flag_wr` stays 0.
- `start` pulsed during CALC → ignored, single result. `rst_n` low in the second CALC cycle → all outputs 0 immediately, no `wr_en` afterwards, next `start` runs cleanly.
- Rd=15, Rm=4, Rs=4 → `done`=1 with `wr_en`=0. Back-to-back starts issued on each IDLE cycle → one `wr_en` per operation, spaced n+2 cycles apart.
